// File: rtl/xor_mlp_trainer.sv
// xor_mlp_trainer: 2-2-1 step-neuron network in sign-magnitude
// fixed point, with sample memory and perceptron-rule training.
module xor_mlp_trainer #(
  parameter int TAM        = 16,
  parameter int FRAC       = 12,
  parameter int N_SAMPLES  = 4,
  parameter int MAX_EPOCHS = 16,
  parameter int ETA_SHIFT  = 0,
  localparam int IW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
  localparam int EW = $clog2(MAX_EPOCHS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 ld_en,
  input  logic [IW-1:0]        ld_idx,
  input  logic [TAM-1:0]       ld_x1,
  input  logic [TAM-1:0]       ld_x2,
  input  logic [TAM-1:0]       ld_dz1,
  input  logic [TAM-1:0]       ld_dz2,
  input  logic [TAM-1:0]       ld_d,
  input  logic                 w_wr_en,
  input  logic [3:0]           w_sel,
  input  logic [TAM-1:0]       w_wdata,
  output logic [TAM-1:0]       w_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [EW-1:0]        epoch,
  output logic [N_SAMPLES-1:0] result
);

  localparam int MW = TAM - 1;
  localparam int SW = TAM + 2;
  localparam logic [MW-1:0] MAXM = '1;
  localparam logic [MW-1:0] ONE = MW'(1) << FRAC;
  localparam logic [TAM-1:0] BIAS1 = {1'b0, ONE};

  typedef enum logic [2:0] {
    S_IDLE, S_L1, S_L2, S_UPD, S_NEXT, S_CHECK, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [TAM-1:0] w_q [9];
  logic [TAM-1:0] x1_q [N_SAMPLES];
  logic [TAM-1:0] x2_q [N_SAMPLES];
  logic [TAM-1:0] dz1_q [N_SAMPLES];
  logic [TAM-1:0] dz2_q [N_SAMPLES];
  logic [TAM-1:0] d_q [N_SAMPLES];

  logic [IW-1:0]        i_q;
  logic                 mode_q;
  logic                 err_q;
  logic                 conv_q;
  logic [EW-1:0]        epoch_q;
  logic                 z1_q, z2_q, y_q;
  logic [N_SAMPLES-1:0] result_q;

  logic [TAM-1:0] cx1, cx2, cdz1, cdz2, cd;
  logic signed [SW-1:0] s1, s2, s3;
  logic z1_c, z2_c, y_c;
  logic e1nz, e2nz, e3nz;
  logic last;
  logic [EW-1:0] ep_inc;
  logic ep_max;

  // Magnitude product, truncated and saturated; sign is XOR.
  function automatic logic [TAM-1:0] sm_mul(
    input logic [TAM-1:0] a,
    input logic [TAM-1:0] b
  );
    logic [2*MW-1:0] p;
    logic [2*MW-1:0] m;
    p = {{MW{1'b0}}, a[MW-1:0]} * {{MW{1'b0}}, b[MW-1:0]};
    m = p >> FRAC;
    sm_mul = {a[TAM-1] ^ b[TAM-1],
              (|m[2*MW-1:MW]) ? MAXM : m[MW-1:0]};
  endfunction

  // Sign-magnitude to wide two's complement.
  function automatic logic signed [SW-1:0] sm2tc(
    input logic [TAM-1:0] a
  );
    logic signed [SW-1:0] v;
    v = signed'({3'b000, a[MW-1:0]});
    sm2tc = a[TAM-1] ? -v : v;
  endfunction

  // Saturating conversion back; zero always comes out as +0.
  function automatic logic [TAM-1:0] tc2sm(
    input logic signed [SW-1:0] s
  );
    logic signed [SW-1:0] lim;
    logic signed [SW-1:0] mag;
    lim = signed'({3'b000, MAXM});
    mag = -s;
    if (s > lim) tc2sm = {1'b0, MAXM};
    else if (s < -lim) tc2sm = {1'b1, MAXM};
    else if (s[SW-1]) tc2sm = {1'b1, mag[MW-1:0]};
    else tc2sm = {1'b0, s[MW-1:0]};
  endfunction

  function automatic logic signed [SW-1:0] nsum(
    input logic [TAM-1:0] bias,
    input logic [TAM-1:0] wa,
    input logic [TAM-1:0] a,
    input logic [TAM-1:0] wb,
    input logic [TAM-1:0] b
  );
    nsum = sm2tc(bias) + sm2tc(sm_mul(wa, a))
         + sm2tc(sm_mul(wb, b));
  endfunction

  function automatic logic pos(input logic signed [SW-1:0] s);
    pos = !s[SW-1] && (s != '0);
  endfunction

  function automatic logic cls(input logic [TAM-1:0] t);
    cls = !t[TAM-1] && (|t[MW-1:0]);
  endfunction

  function automatic logic [TAM-1:0] zval(input logic z);
    zval = z ? BIAS1 : '0;
  endfunction

  // w += e*(in>>eta); neg selects e = -1.
  function automatic logic [TAM-1:0] upd(
    input logic [TAM-1:0] w,
    input logic [TAM-1:0] in,
    input logic           neg
  );
    logic [TAM-1:0] dlt;
    dlt = {in[TAM-1] ^ neg, in[MW-1:0] >> ETA_SHIFT};
    upd = tc2sm(sm2tc(w) + sm2tc(dlt));
  endfunction

  // Select the current sample from memory.
  always_comb begin
    cx1  = '0;
    cx2  = '0;
    cdz1 = '0;
    cdz2 = '0;
    cd   = '0;
    for (int k = 0; k < N_SAMPLES; k++) begin
      if (i_q == IW'(k)) begin
        cx1  = x1_q[k];
        cx2  = x2_q[k];
        cdz1 = dz1_q[k];
        cdz2 = dz2_q[k];
        cd   = d_q[k];
      end
    end
  end

  assign s1 = nsum(w_q[0], w_q[1], cx1, w_q[2], cx2);
  assign s2 = nsum(w_q[3], w_q[4], cx1, w_q[5], cx2);
  assign s3 = nsum(w_q[6], w_q[7], zval(z1_q),
                   w_q[8], zval(z2_q));
  assign z1_c = pos(s1);
  assign z2_c = pos(s2);
  assign y_c  = pos(s3);

  // A neuron errs when its output differs from its target class.
  assign e1nz = cls(cdz1) != z1_q;
  assign e2nz = cls(cdz2) != z2_q;
  assign e3nz = cls(cd) != y_q;

  assign last   = i_q == IW'(N_SAMPLES - 1);
  assign ep_inc = epoch_q + EW'(1);
  assign ep_max = ep_inc == EW'(MAX_EPOCHS);

  // Combinational weight read port.
  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < 9; k++) begin
      if (w_sel == 4'(k)) w_rdata = w_q[k];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_L1;
      S_L1:    state_d = S_L2;
      S_L2:    state_d = mode_q ? S_UPD : S_NEXT;
      S_UPD:   state_d = S_NEXT;
      S_NEXT: begin
        if (!last) state_d = S_L1;
        else state_d = mode_q ? S_CHECK : S_DONE;
      end
      S_CHECK: begin
        if (!err_q || ep_max) state_d = S_DONE;
        else state_d = S_L1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  // Run control: sample index, epoch count, error and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= 1'b0;
      i_q      <= '0;
      err_q    <= 1'b0;
      conv_q   <= 1'b0;
      epoch_q  <= '0;
      z1_q     <= 1'b0;
      z2_q     <= 1'b0;
      y_q      <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            i_q     <= '0;
            err_q   <= 1'b0;
            conv_q  <= 1'b0;
            epoch_q <= '0;
          end
        end
        S_L1: begin
          z1_q <= z1_c;
          z2_q <= z2_c;
        end
        S_L2: begin
          y_q <= y_c;
          for (int k = 0; k < N_SAMPLES; k++) begin
            if (i_q == IW'(k)) result_q[k] <= y_c;
          end
        end
        S_UPD: begin
          if (e1nz || e2nz || e3nz) err_q <= 1'b1;
        end
        S_NEXT: begin
          i_q <= last ? '0 : i_q + IW'(1);
        end
        S_CHECK: begin
          epoch_q <= ep_inc;
          conv_q  <= !err_q;
          err_q   <= 1'b0;
          i_q     <= '0;
        end
        default: ;
      endcase
    end
  end

  // Weights: host writes in IDLE, perceptron updates in UPD.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) w_q[k] <= '0;
    end else if (state_q == S_IDLE) begin
      for (int k = 0; k < 9; k++) begin
        if (w_wr_en && w_sel == 4'(k)) w_q[k] <= w_wdata;
      end
    end else if (state_q == S_UPD) begin
      if (e1nz) begin
        w_q[0] <= upd(w_q[0], BIAS1, z1_q);
        w_q[1] <= upd(w_q[1], cx1, z1_q);
        w_q[2] <= upd(w_q[2], cx2, z1_q);
      end
      if (e2nz) begin
        w_q[3] <= upd(w_q[3], BIAS1, z2_q);
        w_q[4] <= upd(w_q[4], cx1, z2_q);
        w_q[5] <= upd(w_q[5], cx2, z2_q);
      end
      if (e3nz) begin
        w_q[6] <= upd(w_q[6], BIAS1, y_q);
        w_q[7] <= upd(w_q[7], zval(z1_q), y_q);
        w_q[8] <= upd(w_q[8], zval(z2_q), y_q);
      end
    end
  end

  // Sample memory, writable only in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_SAMPLES; k++) begin
        x1_q[k]  <= '0;
        x2_q[k]  <= '0;
        dz1_q[k] <= '0;
        dz2_q[k] <= '0;
        d_q[k]   <= '0;
      end
    end else if (state_q == S_IDLE && ld_en) begin
      for (int k = 0; k < N_SAMPLES; k++) begin
        if (ld_idx == IW'(k)) begin
          x1_q[k]  <= ld_x1;
          x2_q[k]  <= ld_x2;
          dz1_q[k] <= ld_dz1;
          dz2_q[k] <= ld_dz2;
          d_q[k]   <= ld_d;
        end
      end
    end
  end

  assign busy      = !(state_q == S_IDLE || state_q == S_DONE);
  assign done      = state_q == S_DONE;
  assign converged = conv_q;
  assign epoch     = epoch_q;
  assign result    = result_q;

endmodule

// File: tb/tb_xor_mlp_trainer.sv
// tb_xor_mlp_trainer: scoreboard bench with an integer-valued
// network model for xor_mlp_trainer.
module tb_xor_mlp_trainer;

  localparam int N    = 4;
  localparam int MAXE = 16;
  localparam int FRAC = 12;
  localparam int ETA  = 0;
  localparam int ONE  = 1 << FRAC;
  localparam int MAXV = 32767;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        ld_en = 1'b0;
  logic [1:0]  ld_idx = '0;
  logic [15:0] ld_x1 = '0, ld_x2 = '0;
  logic [15:0] ld_dz1 = '0, ld_dz2 = '0, ld_d = '0;
  logic        w_wr_en = 1'b0;
  logic [3:0]  w_sel = '0;
  logic [15:0] w_wdata = '0;
  logic [15:0] w_rdata;
  logic        busy, done, converged;
  logic [4:0]  epoch;
  logic [3:0]  result;

  xor_mlp_trainer dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_x1(ld_x1), .ld_x2(ld_x2),
    .ld_dz1(ld_dz1), .ld_dz2(ld_dz2), .ld_d(ld_d),
    .w_wr_en(w_wr_en), .w_sel(w_sel), .w_wdata(w_wdata),
    .w_rdata(w_rdata), .busy(busy), .done(done),
    .converged(converged), .epoch(epoch), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int res;
    int conv;
    int ep;
    int lat;
    int t0;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  int mw[9];
  int mx1[N], mx2[N], mt1[N], mt2[N], mtd[N];

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [15:0] i2sm(input int v);
    if (v < 0) return {1'b1, 15'(-v)};
    return {1'b0, 15'(v)};
  endfunction

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  function automatic int sat(input longint v);
    if (v > MAXV) return MAXV;
    if (v < -MAXV) return -MAXV;
    return int'(v);
  endfunction

  function automatic int mmul(input int a, input int b);
    longint p;
    p = (longint'(iabs(a)) * longint'(iabs(b))) >> FRAC;
    if (p > MAXV) p = MAXV;
    return ((a < 0) != (b < 0)) ? -int'(p) : int'(p);
  endfunction

  function automatic int neur(input int b, input int wa,
                              input int a, input int wb,
                              input int c);
    longint s;
    s = longint'(b) + mmul(wa, a) + mmul(wb, c);
    return (sat(s) > 0) ? 1 : 0;
  endfunction

  function automatic int step(input int in, input int e);
    int m;
    m = in < 0 ? -((-in) >> ETA) : (in >> ETA);
    return e * m;
  endfunction

  function automatic int upw(input int w, input int e,
                             input int in);
    return sat(longint'(w) + step(in, e));
  endfunction

  // Whole run at network level: returns outputs and latency.
  task automatic model_run(input bit train, output exp_t r);
    int ep, z1, z2, y, e1, e2, e3;
    bit err;
    r.res = 0;
    r.conv = 0;
    ep = 0;
    forever begin
      err = 0;
      for (int i = 0; i < N; i++) begin
        z1 = neur(mw[0], mw[1], mx1[i], mw[2], mx2[i]);
        z2 = neur(mw[3], mw[4], mx1[i], mw[5], mx2[i]);
        y  = neur(mw[6], mw[7], z1 * ONE, mw[8], z2 * ONE);
        r.res = y ? (r.res | (1 << i)) : (r.res & ~(1 << i));
        if (train) begin
          e1 = (mt1[i] > 0 ? 1 : 0) - z1;
          e2 = (mt2[i] > 0 ? 1 : 0) - z2;
          e3 = (mtd[i] > 0 ? 1 : 0) - y;
          if (e1 != 0 || e2 != 0 || e3 != 0) err = 1;
          mw[0] = upw(mw[0], e1, ONE);
          mw[1] = upw(mw[1], e1, mx1[i]);
          mw[2] = upw(mw[2], e1, mx2[i]);
          mw[3] = upw(mw[3], e2, ONE);
          mw[4] = upw(mw[4], e2, mx1[i]);
          mw[5] = upw(mw[5], e2, mx2[i]);
          mw[6] = upw(mw[6], e3, ONE);
          mw[7] = upw(mw[7], e3, z1 * ONE);
          mw[8] = upw(mw[8], e3, z2 * ONE);
        end
      end
      if (!train) break;
      ep++;
      if (!err) begin
        r.conv = 1;
        break;
      end
      if (ep == MAXE) break;
    end
    r.ep  = ep;
    r.lat = train ? ep * (4 * N + 1) + 1 : 3 * N + 1;
  endtask

  // Monitor: every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done: got done=1 expected none");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", int'(result), e.res);
        chk("converged", int'(converged), e.conv);
        chk("epoch", int'(epoch), e.ep);
        chk("latency", cyc - e.t0, e.lat);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic wr_w(input int sel, input int v);
    @(negedge clk);
    w_wr_en = 1'b1;
    w_sel = 4'(sel);
    w_wdata = i2sm(v);
    mw[sel] = v;
    @(negedge clk);
    w_wr_en = 1'b0;
  endtask

  task automatic wr_all(input int a0, input int a1, input int a2,
                        input int a3, input int a4, input int a5,
                        input int a6, input int a7, input int a8);
    wr_w(0, a0); wr_w(1, a1); wr_w(2, a2);
    wr_w(3, a3); wr_w(4, a4); wr_w(5, a5);
    wr_w(6, a6); wr_w(7, a7); wr_w(8, a8);
  endtask

  task automatic ld_s(input int i, input int x1, input int x2,
                      input int t1, input int t2, input int td);
    @(negedge clk);
    ld_en = 1'b1;
    ld_idx = 2'(i);
    ld_x1 = i2sm(x1);
    ld_x2 = i2sm(x2);
    ld_dz1 = i2sm(t1);
    ld_dz2 = i2sm(t2);
    ld_d = i2sm(td);
    mx1[i] = x1; mx2[i] = x2;
    mt1[i] = t1; mt2[i] = t2; mtd[i] = td;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic chk_weights();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      w_sel = 4'(k);
      #1;
      chk($sformatf("w_rdata[%0d]", k), int'(w_rdata),
          int'(i2sm(mw[k])));
    end
  endtask

  // Start a run; optional weight write in the start cycle and
  // optional ignored host activity while busy.
  task automatic run(input bit train, input bit disturb,
                     input int cw_sel, input int cw_v);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    mode = train;
    if (cw_sel >= 0) begin
      w_wr_en = 1'b1;
      w_sel = 4'(cw_sel);
      w_wdata = i2sm(cw_v);
      mw[cw_sel] = cw_v;
    end
    model_run(train, e);
    e.t0 = cyc;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    mode = 1'b0;
    w_wr_en = 1'b0;
    chk("busy_rise", int'(busy), 1);
    if (disturb) begin
      repeat (3) @(negedge clk);
      chk("busy_mid", int'(busy), 1);
      start = 1'b1; mode = ~train;
      ld_en = 1'b1; ld_idx = 2'd0;
      ld_x1 = 16'h7abc; ld_dz1 = 16'h1000;
      w_wr_en = 1'b1; w_sel = 4'd0; w_wdata = 16'h1234;
      @(negedge clk);
      start = 1'b0; mode = 1'b0;
      ld_en = 1'b0; w_wr_en = 1'b0;
    end
    for (int k = 0; k < 400 && sbq.size() != 0; k++)
      @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL run_timeout: got no done expected done");
      sbq.delete();
    end
    @(negedge clk);
  endtask

  function automatic int rw();
    int m;
    m = $urandom_range(0, 6144);
    return ($urandom_range(0, 1) == 1 && m != 0) ? -m : m;
  endfunction

  function automatic int rx();
    if ($urandom_range(0, 3) == 0) return rw();
    return $urandom_range(0, 1) == 1 ? ONE : 0;
  endfunction

  function automatic int rt();
    if ($urandom_range(0, 1) == 0) return 0;
    if ($urandom_range(0, 3) == 0)
      return int'($urandom_range(1, 32767));
    return ONE;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 9; k++) mw[k] = 0;
    for (int i = 0; i < N; i++) begin
      mx1[i] = 0; mx2[i] = 0;
      mt1[i] = 0; mt2[i] = 0; mtd[i] = 0;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_conv"}, int'(converged), 0);
    chk({tag, "_epoch"}, int'(epoch), 0);
    chk({tag, "_result"}, int'(result), 0);
    for (int k = 0; k < 16; k++) begin
      w_sel = 4'(k);
      #1;
      chk($sformatf("%s_w%0d", tag, k), int'(w_rdata), 0);
    end
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");

    // XOR inference with hand-set weights; w2 lands with start.
    ld_s(0, 0, 0, 0, 0, 0);
    ld_s(1, ONE, 0, ONE, 0, ONE);
    ld_s(2, 0, ONE, 0, ONE, ONE);
    ld_s(3, ONE, ONE, 0, 0, 0);
    wr_w(0, -2048); wr_w(1, 4096); wr_w(2, -4096);
    wr_w(3, -2048); wr_w(4, -4096); wr_w(5, 4096);
    wr_w(6, -2048); wr_w(7, 4096); wr_w(8, 0);
    run(1'b0, 1'b0, 8, 4096);
    chk("xor_infer", int'(result), 4'b0110);
    chk_weights();

    // Training from the partial start, with ignored host activity.
    wr_all(-2048, 2048, -4096, -2048, -2048, 2048,
           -2048, 2048, 2048);
    run(1'b1, 1'b1, -1, 0);
    chk("train_conv", int'(converged), 1);
    chk_weights();
    run(1'b0, 1'b0, -1, 0);
    chk("trained_xor", int'(result), 4'b0110);

    // Non-separable hidden target runs out of epochs.
    ld_s(2, 0, ONE, ONE, ONE, ONE);
    wr_all(-2048, 2048, -4096, -2048, -2048, 2048,
           -2048, 2048, 2048);
    run(1'b1, 1'b0, -1, 0);
    chk("nonsep_conv", int'(converged), 0);
    chk("nonsep_epoch", int'(epoch), MAXE);
    chk_weights();

    // Saturating products and sums must not wrap.
    ld_s(0, MAXV, MAXV, 0, 0, 0);
    ld_s(1, 0, 0, 0, 0, 0);
    ld_s(2, 0, 0, 0, 0, 0);
    ld_s(3, 0, 0, 0, 0, 0);
    wr_all(MAXV, MAXV, MAXV, 0, 0, 0, 0, ONE, 0);
    run(1'b0, 1'b0, -1, 0);
    chk("sat_z1", int'(result[0]), 1);

    // Positive update on a saturated bias stays saturated.
    for (int i = 0; i < N; i++) ld_s(i, MAXV, 0, ONE, 0, 0);
    wr_all(MAXV, -MAXV, 0, 0, 0, 0, 0, 0, 0);
    run(1'b1, 1'b0, -1, 0);
    chk_weights();
    @(negedge clk);
    w_sel = 4'd0;
    #1;
    chk("sat_bias", int'(w_rdata), 16'h7fff);

    // Sum exactly zero gives output 0; unused selects read 0.
    ld_s(0, ONE, 0, 0, 0, 0);
    for (int i = 1; i < N; i++) ld_s(i, 0, 0, 0, 0, 0);
    wr_all(-2048, 2048, 0, 0, 0, 0, 0, ONE, 0);
    run(1'b0, 1'b0, -1, 0);
    chk("zero_sum", int'(result[0]), 0);
    for (int k = 9; k < 16; k++) begin
      @(negedge clk);
      w_sel = 4'(k);
      #1;
      chk($sformatf("w_sel%0d", k), int'(w_rdata), 0);
    end

    // Randomized sample sets, weights and modes.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++)
        ld_s(i, rx(), rx(), rt(), rt(), rt());
      wr_all(rw(), rw(), rw(), rw(), rw(), rw(),
             rw(), rw(), rw());
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          -1, 0);
      chk_weights();
    end

    // Reset in the middle of a training epoch.
    ld_s(0, ONE, 0, ONE, 0, ONE);
    wr_all(-2048, 2048, -4096, -2048, -2048, 2048,
           -2048, 2048, 2048);
    run(1'b0, 1'b0, -1, 0);
    @(negedge clk);
    start = 1'b1;
    mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_clear();
    chk_reset_state("midrst");
    rst = 1'b0;
    @(negedge clk);
    run(1'b0, 1'b0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xor_mlp_trainer.md
# xor_mlp_trainer

Sequential 2-2-1 perceptron network (two hidden step neurons, one output step neuron) in sign-magnitude fixed-point, with on-chip sample memory and perceptron-rule training. It succeeds the combinational XOR neuron datapaths: it runs multi-epoch training until convergence or an epoch limit, and it runs inference over the stored set. Width, fraction bits, sample count, learning rate and epoch limit are parameters.

## Interface
- TAM, 16, word width; sign-magnitude: bit TAM-1 is the sign, the rest is the magnitude
- FRAC, 12, fraction bits; 1.0 = 1<<FRAC
- N_SAMPLES, 4, sample memory depth (≥1)
- MAX_EPOCHS, 16, training epoch limit (≥1)
- ETA_SHIFT, 0, learning rate = 2^-ETA_SHIFT
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle start pulse; sampled only in IDLE
- mode  in  1  0 = infer, 1 = train; sampled with start
- ld_en  in  1  sample write; honoured only in IDLE
- ld_idx  in  clog2(N_SAMPLES)  sample index
- ld_x1, ld_x2  in  TAM  inputs
- ld_dz1, ld_dz2, ld_d  in  TAM  hidden and output targets; 0 means class 0, any positive nonzero value means class 1
- w_wr_en  in  1  weight write; honoured only in IDLE
- w_sel  in  4  0..8 = w01,w11,w21,w02,w12,w22,w0,w1,w2; 9..15 = no effect, read 0
- w_wdata  in  TAM  weight write data
- w_rdata  out  TAM  weight[w_sel], combinational
- busy  out  1  high outside IDLE/DONE
- done  out  1  one-cycle pulse on entering DONE
- converged  out  1  last training run ended error-free; held until next start
- epoch  out  clog2(MAX_EPOCHS+1)  completed epochs of last run
- result  out  N_SAMPLES  bit i = network output for sample i, updated every pass

## Operation
- Neuron: s = bias + wa·a + wb·b; out = 1.0 if s > 0, else 0. s = 0 and s = −0 give 0.
- Hidden: z1 uses (w01,w11,w21) on (x1,x2); z2 uses (w02,w12,w22). Output: y uses (w0,w1,w2) on the computed (z1,z2).
- Multiply: product magnitude = (|a|·|b|)>>FRAC, truncated, then saturated to 2^(TAM-1)-1. Sign = XOR of the operand signs.
- Add: operands go to (TAM+2)-bit two's complement; the 3-term sum saturates to ±(2^(TAM-1)-1). A −0 result is normalised to +0.
- Training update per neuron: e = target_class − out, with e ∈ {−1,0,+1}. Bias gets w += e·(1.0>>ETA_SHIFT). Each input weight gets w += e·(input>>ETA_SHIFT): shift the magnitude, keep the sign. The add saturates.
- The output neuron trains on the computed z1,z2. The update uses the pre-update weights of the same sample.
- FSM:
  - IDLE → L1 on start.
  - L1 (hidden sums) → L2 (output sum, result[i] written).
  - L2 → UPD if train; else NEXT.
  - UPD → NEXT.
  - NEXT: i++ → L1; on the last sample: infer → DONE; train → CHECK.
  - CHECK: epoch++. If no e≠0 occurred in the epoch: converged=1, DONE. Else if epoch = MAX_EPOCHS: converged=0, DONE. Else i=0 → L1.
  - DONE → IDLE after one cycle.
- start, ld_en and w_wr_en are ignored outside IDLE.

## Timing
- Reset: state=IDLE, all weights=0, sample memory=0, busy=0, done=0, converged=0, epoch=0, result=0.
- Reset mid-run aborts on the next edge. Nothing is preserved.
- Sample and weight writes take effect on the clock edge; a read in the following cycle returns the new value.
- busy rises the cycle after start.
- Per sample: infer 3 cycles (L1, L2, NEXT); train 4 cycles (+UPD).
- Infer run = 3·N_SAMPLES + 1 cycles from start to done.
- Train epoch = 4·N_SAMPLES + 1 cycles (CHECK included).
- start coincident with ld_en/w_wr_en in IDLE: the write lands and the run uses the new values.

## Test plan
- Load XOR (x1=0,1,0,1; x2=0,0,1,1; 1.0=0x1000). Write weights w01=−0.5, w11=1, w21=−1, w02=−0.5, w12=−1, w22=1, w0=−0.5, w1=1, w2=1. Infer → result=4'b0110; done exactly 13 cycles after start; weights unchanged.
- Same samples with targets dz1=0010, dz2=0100, d=0110 by sample. Initial weights w01=−0.5, w11=0.5, w21=−1, w02=−0.5, w12=−0.5, w22=0.5, w0=−0.5, w1=0.5, w2=0.5. Train → converged=1, epoch≤16; then infer → result=0110.
- Hidden target dz1=0110 (XOR, not separable) → done with converged=0, epoch=16; training time 16·17 cycles.
- Saturation: x1=0x7FFF, w11=0x7FFF, other inputs and weights 0 → z1=1, no overflow wrap. w01=0x7FFF plus positive update stays 0x7FFF.
- A start pulse and ld_en/w_wr_en while busy are ignored. rst asserted mid-epoch → next cycle all outputs at reset values; w_rdata=0 for every w_sel.
- Boundary: s exactly 0 (w01=−0.5, w11=0.5, x1=1.0) → output 0. w_sel=12 read → 0.
